mbus_arbiter: RTL
=================

# mbus_arbiter

Parametrised N-master, single-slave memory-bus arbiter that replaces the hand-written debugger/data/instruction mux in the SoC top. It sits between the bus masters (debug unit, CPU data bus, CPU instruction bus, future DMA) and the shared RAM/ROM/MMIO OR-bus. It serialises requests under a selectable fixed-priority or round-robin policy and drives the bus for a configurable read latency. It returns a one-cycle accept/response pulse to the winner, and issues exactly one write strobe per transaction.

## Interface
- N_MASTERS, 3: number of masters, 2..8; index 0 is highest priority in fixed mode
- ADDR_W, 18: address width
- DATA_W, 32: data width; mask width is DATA_W/8
- MODE, 0: 0 = fixed priority, 1 = round-robin
- RD_LATENCY, 1: slave read latency in cycles, 1..15
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m_cmd_valid  in  N_MASTERS  request per master; command must stay stable until m_cmd_ready
- m_cmd_wr  in  N_MASTERS  1 = write
- m_cmd_mask  in  N_MASTERS*DATA_W/8  byte enables, packed master 0 in LSBs
- m_cmd_adr  in  N_MASTERS*ADDR_W  byte address, packed
- m_cmd_data  in  N_MASTERS*DATA_W  write data, packed
- m_cmd_ready  out  N_MASTERS  one-cycle accept pulse, coincident with m_rsp_valid
- m_rsp_valid  out  N_MASTERS  one-cycle response pulse
- m_rsp_error  out  1  registered bus error for the current response
- m_rsp_data  out  DATA_W  registered read data, shared by all masters
- bus_op  out  1  bus select (slave chip-select qualifier)
- bus_adr  out  ADDR_W  latched address
- bus_wren  out  DATA_W/8  byte write enables
- bus_di  out  DATA_W  latched write data
- bus_do  in  DATA_W  OR-bus read data
- bus_err  in  1  decode error from the top-level address decoder

## Operation
- FSM states: IDLE → BUSY → RESP → IDLE.
- IDLE:
  - If any m_cmd_valid is set, pick a winner, latch its wr/mask/adr/data and index, load cnt = RD_LATENCY, and go to BUSY.
  - With no request, stay in IDLE with all bus outputs 0.
- Fixed mode: the lowest set index wins.
- Round-robin mode:
  - Search starts at last_winner+1 and wraps modulo N_MASTERS.
  - last_winner updates on every grant.
  - Reset value of last_winner is N_MASTERS-1, so master 0 is first.
- BUSY:
  - bus_op = 1 and bus_adr/bus_di come from the latch.
  - bus_wren = latched mask, only if wr is set and only in the first BUSY cycle; otherwise 0. This makes MMIO writes single-shot.
  - cnt decrements each cycle. When cnt == 0, sample bus_do into m_rsp_data and bus_err into m_rsp_error, then go to RESP.
  - Write transactions also use the full RD_LATENCY so both access types share one length.
- RESP:
  - m_cmd_ready[w] = m_rsp_valid[w] = 1 for the winner w only; bus_op = 0.
  - Always return to IDLE. No arbitration happens in RESP.
- A master that drops m_cmd_valid mid-transaction does not abort it; the pulse is still issued.
- m_rsp_data and m_rsp_error hold their values until the next capture.
- Requests from non-winners are never lost. They stay pending as long as valid stays high.

## Timing
- Request seen in IDLE at cycle T:
  - bus_op high during cycles T+1 … T+1+RD_LATENCY.
  - Response pulse at cycle T+2+RD_LATENCY.
  - Earliest next grant decision at T+3+RD_LATENCY.
- Throughput: one transaction per RD_LATENCY+3 cycles.
- Reset values: state IDLE, all outputs 0, cnt 0, last_winner N_MASTERS-1.
- Reset mid-transaction:
  - bus_op and bus_wren drop asynchronously.
  - No pulse is issued and the transaction is lost.
- Simultaneous requests: exactly one grant per IDLE cycle. No combinational path from m_cmd_valid to any output.
- cnt width: $clog2(RD_LATENCY+1).

## Structure
- Package mbus_pkg holds:
  - state enum {IDLE, BUSY, RESP}
  - MODE_FIXED / MODE_RR constants
  - packed-slice helper widths
- Sub-module mbus_rr_pick: combinational winner select. Inputs are the request vector, last_winner and mode; outputs are a one-hot grant and the winner index. It is reused by a future DMA arbiter.
- The top keeps address decoding and bus_err generation; they stay outside this block.

## Test plan
- N=3, fixed mode, RD_LATENCY=1; master 1 reads 0x00010 with RAM model returning 0xDEADBEEF one cycle after select → bus_op high 2 cycles; pulse on m_rsp_valid[1] at T+3; m_rsp_data = 0xDEADBEEF.
- Masters 0 and 2 request in the same cycle, fixed mode → master 0 served first and master 2 immediately after; exactly 2 pulses, in order 0 then 2.
- Round-robin mode, all 3 masters hold valid for 6 transactions → grant order 0,1,2,0,1,2.
- Master 2 writes 0xA5 with mask 4'b0001 to UART data, RD_LATENCY=3 → bus_wren = 4'b0001 for exactly 1 cycle of 4 bus_op cycles; UART model receives one byte.
- Read with bus_err=1 → m_rsp_error=1 in the response cycle; next clean read gives m_rsp_error=0.
- Assert reset during the second BUSY cycle → bus_op/bus_wren low immediately, no m_rsp_valid pulse; after release, a pending request is granted with last_winner behaviour as from reset.

Source files
------------

// File: rtl/mbus_pkg.sv
// Shared types and constants for the memory-bus arbiter and its winner picker.
package mbus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int idx_w(input int n_masters);
    return (n_masters > 2) ? $clog2(n_masters) : 1;
  endfunction

  function automatic int mask_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mbus_arbiter_if.sv
// Master-side command/response bundle plus the shared OR-bus; 'slave' is the
// arbiter's view, 'master' is the view of the requesters and the bus responder.
interface mbus_arbiter_if #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 32
);
  logic [N_MASTERS-1:0]          m_cmd_valid;
  logic [N_MASTERS-1:0]          m_cmd_wr;
  logic [N_MASTERS*DATA_W/8-1:0] m_cmd_mask;
  logic [N_MASTERS*ADDR_W-1:0]   m_cmd_adr;
  logic [N_MASTERS*DATA_W-1:0]   m_cmd_data;
  logic [N_MASTERS-1:0]          m_cmd_ready;
  logic [N_MASTERS-1:0]          m_rsp_valid;
  logic                          m_rsp_error;
  logic [DATA_W-1:0]             m_rsp_data;
  logic                          bus_op;
  logic [ADDR_W-1:0]             bus_adr;
  logic [DATA_W/8-1:0]           bus_wren;
  logic [DATA_W-1:0]             bus_di;
  logic [DATA_W-1:0]             bus_do;
  logic                          bus_err;

  modport slave (
    input  m_cmd_valid, m_cmd_wr, m_cmd_mask, m_cmd_adr, m_cmd_data, bus_do, bus_err,
    output m_cmd_ready, m_rsp_valid, m_rsp_error, m_rsp_data,
           bus_op, bus_adr, bus_wren, bus_di
  );

  modport master (
    output m_cmd_valid, m_cmd_wr, m_cmd_mask, m_cmd_adr, m_cmd_data, bus_do, bus_err,
    input  m_cmd_ready, m_rsp_valid, m_rsp_error, m_rsp_data,
           bus_op, bus_adr, bus_wren, bus_di
  );
endinterface

// File: rtl/mbus_rr_pick.sv
// Combinational winner select: fixed priority (lowest index) or round-robin
// starting one past the previous winner.
module mbus_rr_pick
  import mbus_pkg::*;
#(
  parameter int N_MASTERS = 3,
  localparam int IDX_W    = idx_w(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_i,
  input  logic                 rr_i,
  output logic [N_MASTERS-1:0] grant_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_o
);

  always_comb begin
    int unsigned j;
    logic [IDX_W-1:0] jj;
    j       = 0;
    jj      = '0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    // Visit candidates in priority order; the first requester found wins.
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      j  = rr_i ? (32'(last_i) + 32'd1 + k) % N_MASTERS : k;
      jj = IDX_W'(j);
      if (!any_o && req_i[jj]) begin
        any_o     = 1'b1;
        grant_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/mbus_arbiter.sv
// N-master, single-slave memory-bus arbiter: grants one request, drives the
// OR-bus for RD_LATENCY+1 cycles, then returns a one-cycle accept/response pulse.
module mbus_arbiter
  import mbus_pkg::*;
#(
  parameter int N_MASTERS  = 3,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int MODE       = MODE_FIXED,
  parameter int RD_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  mbus_arbiter_if.slave mbus
);

  localparam int MASK_W = mask_w(DATA_W);
  localparam int IDX_W  = idx_w(N_MASTERS);
  localparam int CNT_W  = $clog2(RD_LATENCY + 1);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      last_q;
  logic [N_MASTERS-1:0]  win_oh_q;
  logic [N_MASTERS-1:0]  rsp_q;
  logic                  rsp_err_q;
  logic [DATA_W-1:0]     rsp_data_q;
  logic                  bus_op_q;
  logic [ADDR_W-1:0]     bus_adr_q;
  logic [MASK_W-1:0]     bus_wren_q;
  logic [DATA_W-1:0]     bus_di_q;

  logic [N_MASTERS-1:0]  grant;
  logic [IDX_W-1:0]      pick_idx;
  logic                  any_req;
  logic                  sel_wr;
  logic [MASK_W-1:0]     sel_mask;
  logic [ADDR_W-1:0]     sel_adr;
  logic [DATA_W-1:0]     sel_data;

  mbus_rr_pick #(
    .N_MASTERS (N_MASTERS)
  ) u_pick (
    .req_i   (mbus.m_cmd_valid),
    .last_i  (last_q),
    .rr_i    (MODE == MODE_RR),
    .grant_o (grant),
    .idx_o   (pick_idx),
    .any_o   (any_req)
  );

  always_comb begin
    sel_wr   = 1'b0;
    sel_mask = '0;
    sel_adr  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (grant[i]) begin
        sel_wr   = mbus.m_cmd_wr[i];
        sel_mask = mbus.m_cmd_mask[i*MASK_W +: MASK_W];
        sel_adr  = mbus.m_cmd_adr[i*ADDR_W +: ADDR_W];
        sel_data = mbus.m_cmd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= IDX_W'(N_MASTERS - 1);
      win_oh_q   <= '0;
      rsp_q      <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
      bus_op_q   <= 1'b0;
      bus_adr_q  <= '0;
      bus_wren_q <= '0;
      bus_di_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_q <= '0;
          if (any_req) begin
            state_q    <= BUSY;
            cnt_q      <= CNT_W'(RD_LATENCY);
            last_q     <= pick_idx;
            win_oh_q   <= grant;
            bus_op_q   <= 1'b1;
            bus_adr_q  <= sel_adr;
            bus_di_q   <= sel_data;
            bus_wren_q <= sel_wr ? sel_mask : '0;
          end
        end
        BUSY: begin
          // Write strobe lives only in the first BUSY cycle: MMIO sees one write.
          bus_wren_q <= '0;
          if (cnt_q == '0) begin
            state_q    <= RESP;
            rsp_data_q <= mbus.bus_do;
            rsp_err_q  <= mbus.bus_err;
            rsp_q      <= win_oh_q;
            bus_op_q   <= 1'b0;
            bus_adr_q  <= '0;
            bus_di_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          rsp_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mbus.m_cmd_ready = rsp_q;
  assign mbus.m_rsp_valid = rsp_q;
  assign mbus.m_rsp_error = rsp_err_q;
  assign mbus.m_rsp_data  = rsp_data_q;
  assign mbus.bus_op      = bus_op_q;
  assign mbus.bus_adr     = bus_adr_q;
  assign mbus.bus_wren    = bus_wren_q;
  assign mbus.bus_di      = bus_di_q;

endmodule
